router_output_channel: RTL and testbench

//  Output stage of one mesh router port; it sits directly downstream of the router_input_channel instances.

---
 rtl/router_output_channel.sv | 144 ++++++++++++++
 tb/tb_router_output_channel.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_output_channel.sv
// Mesh router output port: per-VC round-robin fill from the input channels on the
// polarity-matched VC while the opposite VC drains downstream over send/ready.

module router_output_vc #(
  parameter int N_IN = 4,
  parameter int DW   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_fill_en,
  input  logic                     i_drain_en,
  input  logic                     i_ready,
  input  logic [N_IN-1:0]          i_elig,
  input  logic [N_IN-1:0][DW-1:0]  i_flits,
  output logic [N_IN-1:0]          o_gnt,
  output logic                     o_full,
  output logic                     o_fire,
  output logic [DW-1:0]            o_buf
);
  localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [PW-1:0] r_ptr;
  logic          r_full;
  logic [DW-1:0] r_buf;

  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_sel;
  logic          w_found;
  logic          w_grant;
  logic [PW-1:0] w_ptr_nxt;

  // First eligible input at or after the pointer, wrapping mod N_IN.
  always_comb begin
    w_idx   = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % N_IN);
      if (!w_found && i_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_grant   = i_fill_en & ~r_full & w_found;
  assign w_ptr_nxt = (w_sel == PW'(N_IN - 1)) ? '0 : w_sel + 1'b1;
  assign o_fire    = i_drain_en & r_full & i_ready;

  always_comb begin
    o_gnt = '0;
    if (w_grant) o_gnt[w_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr  <= '0;
      r_full <= 1'b0;
      r_buf  <= '0;
    end else if (w_grant) begin
      r_buf  <= i_flits[w_sel];
      r_full <= 1'b1;
      r_ptr  <= w_ptr_nxt;
    end else if (o_fire) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_buf  = r_buf;
endmodule

module router_output_channel #(
  parameter int N_IN = 4,
  parameter int DW   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                polarity,
  input  logic [N_IN-1:0]     req,
  input  logic [N_IN*DW-1:0]  data_in,
  output logic [N_IN-1:0]     gnt,
  input  logic                ready_out,
  output logic                send_out,
  output logic [DW-1:0]       data_out,
  output logic [1:0]          buf_full
);
  logic [N_IN-1:0][DW-1:0] w_flits;
  logic [N_IN-1:0]         w_vcbit;
  logic [1:0][N_IN-1:0]    w_elig;
  logic [1:0][N_IN-1:0]    w_gnt;
  logic [1:0][DW-1:0]      w_buf;
  logic [1:0]              w_full;
  logic [1:0]              w_fire;
  logic [1:0]              w_fill_en;
  logic [1:0]              w_drain_en;
  logic [DW-1:0]           w_drain_buf;
  logic                    w_fire_any;

  assign w_flits = data_in;

  always_comb begin
    for (int i = 0; i < N_IN; i++) w_vcbit[i] = w_flits[i][DW-1];
  end

  genvar v;
  generate
    for (v = 0; v < 2; v++) begin : g_vc
      assign w_elig[v]     = req & ((v != 0) ? w_vcbit : ~w_vcbit);
      // Grants are suppressed while reset is asserted.
      assign w_fill_en[v]  = reset & (polarity == (v != 0));
      assign w_drain_en[v] = (polarity != (v != 0));

      router_output_vc #(.N_IN(N_IN), .DW(DW)) u_vc (
        .clk        (clk),
        .reset      (reset),
        .i_fill_en  (w_fill_en[v]),
        .i_drain_en (w_drain_en[v]),
        .i_ready    (ready_out),
        .i_elig     (w_elig[v]),
        .i_flits    (w_flits),
        .o_gnt      (w_gnt[v]),
        .o_full     (w_full[v]),
        .o_fire     (w_fire[v]),
        .o_buf      (w_buf[v])
      );
    end
  endgenerate

  assign gnt         = w_gnt[0] | w_gnt[1];
  assign buf_full    = w_full;
  assign w_fire_any  = w_fire[0] | w_fire[1];
  assign w_drain_buf = polarity ? w_buf[0] : w_buf[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      send_out <= 1'b0;
      data_out <= '0;
    end else begin
      send_out <= w_fire_any;
      data_out <= w_fire_any ? w_drain_buf : '0;
    end
  end
endmodule

// File: tb/tb_router_output_channel.sv
// Bench for router_output_channel: per-scenario tasks plus a scoreboard that
// records granted flits and matches them against send_out/data_out in order.

module tb_router_output_channel;
  localparam int N_IN = 4;
  localparam int DW   = 64;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                polarity = 1'b0;
  logic [N_IN-1:0]     req = '0;
  logic [N_IN*DW-1:0]  data_in = '0;
  logic                ready_out = 1'b0;
  logic [N_IN-1:0]     gnt;
  logic                send_out;
  logic [DW-1:0]       data_out;
  logic [1:0]          buf_full;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  router_output_channel #(.N_IN(N_IN), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .ready_out (ready_out),
    .send_out  (send_out),
    .data_out  (data_out),
    .buf_full  (buf_full)
  );

  always #5 clk = ~clk;

  // Scoreboard: push the granted flit, pop on every send.
  always @(negedge clk) begin
    for (int i = 0; i < N_IN; i++)
      if (gnt[i] === 1'b1) exp_q.push_back(data_in[i*DW +: DW]);
    if (send_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_data: send with data_out=%h but nothing expected", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_out !== mon_exp) begin
          errors++;
          $display("FAIL sb_data: data_out=%h expected=%h", data_out, mon_exp);
        end
      end
    end
  end

  function automatic logic [DW-1:0] flit(input logic vc, input logic [DW-2:0] pl);
    return {vc, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1 polarity = ~polarity;
  endtask

  task automatic wait_pol(input logic p);
    if (polarity !== p) tick();
  endtask

  task automatic set_flit(input int i, input logic [DW-1:0] f);
    data_in[i*DW +: DW] = f;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    tick();
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 4'b1111;
    set_flit(0, flit(1'b0, 63'h11));
    set_flit(1, flit(1'b1, 63'h22));
    set_flit(2, flit(1'b0, 63'h33));
    set_flit(3, flit(1'b1, 63'h44));
    ready_out = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: gnt=%b expected=0000", gnt); end
      tick();
      checks++;
      if (send_out !== 1'b0) begin errors++; $display("FAIL rst_send: send_out=%b expected=0", send_out); end
      checks++;
      if (data_out !== '0) begin errors++; $display("FAIL rst_data: data_out=%h expected=0", data_out); end
      checks++;
      if (buf_full !== 2'b00) begin errors++; $display("FAIL rst_full: buf_full=%b expected=00", buf_full); end
    end
    req   = '0;
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_single();
    wait_pol(1'b0);
    ready_out = 1'b1;
    req = 4'b0001;
    set_flit(0, 64'h0000_0000_0000_FA50);
    #1;
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: gnt=%b expected=0001", gnt); end
    tick();
    req = '0;
    checks++;
    if (buf_full !== 2'b01) begin errors++; $display("FAIL single_full: buf_full=%b expected=01", buf_full); end
    tick();
    checks++;
    if (send_out !== 1'b1 || data_out !== 64'h0000_0000_0000_FA50) begin
      errors++;
      $display("FAIL single_send: send_out=%b data_out=%h expected 1/000000000000fa50", send_out, data_out);
    end
    checks++;
    if (buf_full !== 2'b00) begin errors++; $display("FAIL single_empty: buf_full=%b expected=00", buf_full); end
  endtask

  task automatic test_round_robin();
    logic [N_IN-1:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    wait_pol(1'b0);
    ready_out = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N_IN; i++) set_flit(i, flit(1'b0, 63'(32'h100 * k + i)));
      #1;
      checks++;
      if (gnt !== rr_exp[k]) begin errors++; $display("FAIL rr_gnt[%0d]: gnt=%b expected=%b", k, gnt, rr_exp[k]); end
      tick();
      #1;
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_wrong_vc[%0d]: gnt=%b expected=0000", k, gnt); end
      tick();
    end
    req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    int nsend;
    wait_pol(1'b0);
    ready_out = 1'b0;
    req = 4'b0001;
    set_flit(0, flit(1'b0, 63'hB0B0));
    #1;
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL bp_fill: gnt=%b expected=0001", gnt); end
    tick();
    req = 4'b0100;
    set_flit(2, flit(1'b0, 63'hC0C0));
    for (int c = 0; c < 3; c++) begin
      if (c == 2) req = '0;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt[%0d]: gnt=%b expected=0000", c, gnt); end
      tick();
      checks++;
      if (send_out !== 1'b0 || buf_full[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: send_out=%b buf_full=%b expected 0/x1", c, send_out, buf_full);
      end
    end
    ready_out = 1'b1;
    nsend = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (send_out === 1'b1) begin
        nsend++;
        checks++;
        if (data_out !== flit(1'b0, 63'hB0B0)) begin
          errors++;
          $display("FAIL bp_data: data_out=%h expected=%h", data_out, flit(1'b0, 63'hB0B0));
        end
      end
    end
    checks++;
    if (nsend != 1) begin errors++; $display("FAIL bp_once: sends=%0d expected=1", nsend); end
    checks++;
    if (buf_full !== 2'b00) begin errors++; $display("FAIL bp_empty: buf_full=%b expected=00", buf_full); end
  endtask

  task automatic test_vc_mismatch();
    wait_pol(1'b0);
    ready_out = 1'b1;
    req = 4'b0010;
    set_flit(1, flit(1'b1, 63'hD1D1));
    #1;
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL vc_p0_gnt: gnt=%b expected=0000", gnt); end
    tick();
    #1;
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL vc_p1_gnt: gnt=%b expected=0010", gnt); end
    tick();
    req = '0;
    checks++;
    if (buf_full !== 2'b10) begin errors++; $display("FAIL vc_full: buf_full=%b expected=10", buf_full); end
    tick();
    checks++;
    if (send_out !== 1'b1 || data_out !== flit(1'b1, 63'hD1D1)) begin
      errors++;
      $display("FAIL vc_send: send_out=%b data_out=%h expected 1/%h", send_out, data_out, flit(1'b1, 63'hD1D1));
    end
  endtask

  task automatic test_reset_mid();
    wait_pol(1'b0);
    ready_out = 1'b0;
    req = 4'b0001;
    set_flit(0, flit(1'b0, 63'hE0));
    tick();
    req = 4'b0100;
    set_flit(2, flit(1'b1, 63'hE2));
    tick();
    req = '0;
    checks++;
    if (buf_full !== 2'b11) begin errors++; $display("FAIL mid_full: buf_full=%b expected=11", buf_full); end
    reset = 1'b0;
    ready_out = 1'b1;
    req = 4'b0101;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt: gnt=%b expected=0000", gnt); end
    tick();
    checks++;
    if (buf_full !== 2'b00 || send_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear: buf_full=%b send_out=%b expected 00/0", buf_full, send_out);
    end
    exp_q.delete();
    reset = 1'b1;
    req = '0;
    tick();
    checks++;
    if (send_out !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL mid_nosend: send_out=%b data_out=%h expected 0/0", send_out, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_vc_mismatch();
    test_reset_mid();
    tick();
    tick();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: %0d flits outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
